// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: sequences start, data, optional parity and stop
// bits around an external 8-bit serializer, with a DATA-phase timeout.
module uart_tx_frame_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Data_Valid,
    input  logic [7:0] P_DATA,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic       ser_done,
    input  logic       ser_data,
    output logic       ser_en,
    output logic       busy,
    output logic       TX_OUT,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [3:0] TMO_LIMIT = 4'd9;

    state_t     state;
    state_t     next_state;
    logic       par_bit;
    logic       par_en_q;
    logic [3:0] tmo_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Parity type is folded into the latched parity bit, so only the bit and the enable are kept.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_bit  <= 1'b0;
            par_en_q <= 1'b0;
            tmo_cnt  <= 4'd0;
        end else if (state == IDLE && Data_Valid) begin
            par_bit  <= PAR_TYP ? ~^P_DATA : ^P_DATA;
            par_en_q <= PAR_EN;
            tmo_cnt  <= 4'd0;
        end else if (state == DATA) begin
            tmo_cnt  <= tmo_cnt + 4'd1;
        end
    end

    always_comb begin
        next_state = state;
        ser_en     = 1'b0;
        TX_OUT     = 1'b1;
        frame_err  = 1'b0;
        case (state)
            IDLE: begin
                if (Data_Valid) begin
                    next_state = START;
                end
            end
            START: begin
                TX_OUT     = 1'b0;
                ser_en     = 1'b1;
                next_state = DATA;
            end
            DATA: begin
                TX_OUT = ser_data;
                // A late ser_done still completes the frame normally, even on the limit cycle.
                if (ser_done) begin
                    next_state = par_en_q ? PARITY : STOP;
                end else if (tmo_cnt == TMO_LIMIT) begin
                    frame_err  = 1'b1;
                    next_state = IDLE;
                end else begin
                    ser_en = 1'b1;
                end
            end
            PARITY: begin
                TX_OUT     = par_bit;
                next_state = STOP;
            end
            STOP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl: serializer model, frame-level reference
// queue checked every cycle, plus directed frames with literal line patterns.
module tb_uart_tx_frame_ctrl;

    logic       CLK        = 1'b0;
    logic       RST        = 1'b1;
    logic       Data_Valid = 1'b0;
    logic [7:0] P_DATA     = 8'h00;
    logic       PAR_EN     = 1'b0;
    logic       PAR_TYP    = 1'b0;
    logic       ser_done;
    logic       ser_data   = 1'b1;
    logic       ser_en;
    logic       busy;
    logic       TX_OUT;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;

    logic       stuck_low = 1'b0;
    logic [7:0] ser_reg   = 8'h00;
    int         ser_cnt   = 8;

    typedef struct packed {
        logic tx;
        logic bsy;
        logic en;
        logic fe;
    } exp_t;

    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    uart_tx_frame_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .Data_Valid (Data_Valid),
        .P_DATA     (P_DATA),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_done   (ser_done),
        .ser_data   (ser_data),
        .ser_en     (ser_en),
        .busy       (busy),
        .TX_OUT     (TX_OUT),
        .frame_err  (frame_err)
    );

    // Serializer: loads while the controller is idle, presents bit n after the n-th shift.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            ser_cnt  <= 8;
            ser_data <= 1'b1;
            ser_reg  <= 8'h00;
        end else if (Data_Valid && !busy) begin
            ser_reg <= P_DATA;
            ser_cnt <= 0;
        end else if (ser_en && ser_cnt < 8) begin
            ser_data <= ser_reg[ser_cnt];
            ser_cnt  <= ser_cnt + 1;
        end
    end

    assign ser_done = stuck_low ? 1'b0 : (ser_cnt == 8);

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Whole frame expected from the request, one entry per cycle the controller is busy.
    function automatic void build_frame(input logic [7:0] d, input logic en,
                                        input logic typ, input logic timeout);
        int   ones;
        logic par;
        ones = $countones(d);
        par  = ((ones % 2) == 1) ? 1'b1 : 1'b0;
        if (typ) par = !par;
        exp_q.push_back({1'b0, 1'b1, 1'b1, 1'b0});
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({d[i], 1'b1, (timeout || i < 7) ? 1'b1 : 1'b0, 1'b0});
        end
        if (timeout) begin
            exp_q.push_back({d[7], 1'b1, 1'b1, 1'b0});
            exp_q.push_back({d[7], 1'b1, 1'b0, 1'b1});
        end else begin
            if (en) exp_q.push_back({par, 1'b1, 1'b0, 1'b0});
            exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0});
        end
    endfunction

    always @(posedge CLK or posedge RST) begin
        bit was_idle;
        if (RST) begin
            exp_q.delete();
        end else begin
            was_idle = (exp_q.size() == 0);
            if (!was_idle) void'(exp_q.pop_front());
            if (was_idle && Data_Valid) build_frame(P_DATA, PAR_EN, PAR_TYP, stuck_low);
        end
    end

    always @(negedge CLK) begin
        exp_t e;
        if (RST || exp_q.size() == 0) e = {1'b1, 1'b0, 1'b0, 1'b0};
        else e = exp_q[0];
        check_output("tx_out", TX_OUT, e.tx);
        check_output("busy", busy, e.bsy);
        check_output("ser_en", ser_en, e.en);
        check_output("frame_err", frame_err, e.fe);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] d, input logic en, input logic typ);
        Data_Valid = 1'b1;
        P_DATA     = d;
        PAR_EN     = en;
        PAR_TYP    = typ;
        step();
        Data_Valid = 1'b0;
        P_DATA     = 8'($urandom);
        PAR_TYP    = 1'($urandom);
    endtask

    task automatic capture_frame(output logic [15:0] bits, output int len, output int fe_cnt);
        int guard;
        guard  = 0;
        bits   = '0;
        len    = 0;
        fe_cnt = 0;
        @(negedge CLK);
        while (!busy && guard < 10) begin
            @(negedge CLK);
            guard++;
        end
        while (busy && len < 16) begin
            bits[len] = TX_OUT;
            if (frame_err) fe_cnt++;
            len++;
            @(negedge CLK);
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        check_output("wait_idle", busy, 1'b0);
        step();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] bits;
        int          len;
        int          fe_cnt;

        repeat (3) @(negedge CLK);
        check_output("rst_tx", TX_OUT, 1'b1);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_ser_en", ser_en, 1'b0);
        check_output("rst_frame_err", frame_err, 1'b0);
        step();
        RST = 1'b0;
        step();

        // 0xA5 even parity
        fork
            capture_frame(bits, len, fe_cnt);
            apply_stimulus(8'hA5, 1'b1, 1'b0);
        join
        check_output("a5_even_bits", bits, 16'h054A);
        check_output("a5_even_len", len, 11);
        wait_idle();

        // 0xA5 odd parity
        fork
            capture_frame(bits, len, fe_cnt);
            apply_stimulus(8'hA5, 1'b1, 1'b1);
        join
        check_output("a5_odd_bits", bits, 16'h074A);
        check_output("a5_odd_len", len, 11);
        wait_idle();

        // 0x00 without parity
        fork
            capture_frame(bits, len, fe_cnt);
            apply_stimulus(8'h00, 1'b0, 1'b0);
        join
        check_output("00_nopar_bits", bits, 16'h0200);
        check_output("00_nopar_len", len, 10);
        wait_idle();

        // 0x5A with a 0xFF request arriving mid-frame
        fork
            capture_frame(bits, len, fe_cnt);
            begin
                apply_stimulus(8'h5A, 1'b1, 1'b0);
                repeat (3) step();
                Data_Valid = 1'b1;
                P_DATA     = 8'hFF;
                step();
                Data_Valid = 1'b0;
            end
        join
        check_output("5a_ignore_bits", bits, 16'h04B4);
        check_output("5a_ignore_len", len, 11);
        @(negedge CLK);
        check_output("5a_no_second", busy, 1'b0);
        wait_idle();

        // 0x01 with PAR_EN dropped during DATA
        fork
            capture_frame(bits, len, fe_cnt);
            begin
                apply_stimulus(8'h01, 1'b1, 1'b0);
                repeat (2) step();
                PAR_EN  = 1'b0;
                PAR_TYP = 1'b1;
            end
        join
        check_output("01_latched_bits", bits, 16'h0602);
        check_output("01_latched_len", len, 11);
        wait_idle();

        // serializer never signals done
        stuck_low = 1'b1;
        fork
            capture_frame(bits, len, fe_cnt);
            apply_stimulus(8'h3C, 1'b1, 1'b0);
        join
        check_output("tmo_fe_pulses", fe_cnt, 1);
        check_output("tmo_len", len, 11);
        check_output("tmo_idle_tx", TX_OUT, 1'b1);
        check_output("tmo_idle_busy", busy, 1'b0);
        stuck_low = 1'b0;
        wait_idle();

        // reset in DATA cycle 3
        apply_stimulus(8'h3C, 1'b1, 1'b0);
        repeat (3) step();
        RST = 1'b1;
        #1;
        check_output("midrst_tx", TX_OUT, 1'b1);
        check_output("midrst_busy", busy, 1'b0);
        check_output("midrst_ser_en", ser_en, 1'b0);
        check_output("midrst_frame_err", frame_err, 1'b0);
        repeat (2) step();
        RST = 1'b0;
        step();
        fork
            capture_frame(bits, len, fe_cnt);
            apply_stimulus(8'h3C, 1'b1, 1'b0);
        join
        check_output("3c_after_rst_bits", bits, 16'h0478);
        check_output("3c_after_rst_len", len, 11);
        wait_idle();

        // random traffic, including requests and field changes while busy
        for (int i = 0; i < 400; i++) begin
            Data_Valid = ($urandom_range(0, 3) == 0);
            P_DATA     = 8'($urandom);
            PAR_EN     = 1'($urandom);
            PAR_TYP    = 1'($urandom);
            step();
        end
        Data_Valid = 1'b0;
        wait_idle();
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
